// File: rtl/stack_ctrl_seq_if.sv
// Instruction fetch handshake between the fetch unit and the stack controller.
// The fetch side drives the word and valid; the controller answers with ready.
interface stack_ctrl_seq_if #(
    parameter int REG_BITS = 32
);
    logic                instr_valid;
    logic [REG_BITS-1:0] instruction;
    logic                instr_ready;

    modport master (
        output instr_valid,
        output instruction,
        input  instr_ready
    );

    modport slave (
        input  instr_valid,
        input  instruction,
        output instr_ready
    );
endinterface

// File: rtl/stack_ctrl_seq.sv
// Registered stack-machine decoder with occupancy tracking.
// Bad stack accesses park the unit in a sticky fault state.
module stack_ctrl_seq #(
    parameter int REG_BITS = 32,
    parameter int SP_BITS  = 4
) (
    input  logic               clk,
    input  logic               reset,
    stack_ctrl_seq_if.slave    fetch,
    input  logic               fault_clear,
    output logic               ctrl_valid,
    output logic               ALUOp,
    output logic [1:0]         PCSrc,
    output logic               MemRead,
    output logic               MemWrite,
    output logic [1:0]         StackWriteSrc,
    output logic               ALUSrc,
    output logic [1:0]         StackUpdateMode,
    output logic [SP_BITS:0]   sp,
    output logic               fault,
    output logic [1:0]         fault_code
);
    localparam int DEPTH = 2 ** SP_BITS;
    localparam int W     = SP_BITS + 3;

    typedef enum logic {RUN, FAULT} state_t;

    typedef struct packed {
        logic       alu;
        logic [1:0] pcs;
        logic       mr;
        logic       mw;
        logic [1:0] sws;
        logic       as;
        logic [1:0] sum;
    } ctrl_t;

    state_t              state, state_n;
    logic [SP_BITS:0]    sp_n;
    logic [1:0]          code_n;
    logic                cv_n;
    ctrl_t               ctrl_q, ctrl_n, dec;
    logic [2:0]          op1, op2;
    logic                imm_op;
    logic [1:0]          need;
    logic signed [2:0]   delta;
    logic signed [W-1:0] sum;
    logic                under, over, accept;
    logic                unused_bits;

    assign unused_bits = ^fetch.instruction[REG_BITS-7:0];
    assign op1 = fetch.instruction[REG_BITS-1 -: 3];
    assign op2 = fetch.instruction[REG_BITS-4 -: 3];
    assign imm_op = (op2 == 3'b010) || (op2 == 3'b111);

    always_comb begin
        dec   = '0;
        need  = 2'd0;
        delta = 3'sd0;
        unique case (1'b1)
            op1 == 3'b000: begin
                dec.sws = 2'b01;
                need    = imm_op ? 2'd1 : 2'd2;
                delta   = imm_op ? 3'sd0 : -3'sd1;
                dec.sum = imm_op ? 2'b00 : 2'b11;
            end
            op1 == 3'b001: begin
                dec.sws = 2'b01;
                dec.as  = 1'b1;
                need    = imm_op ? 2'd0 : 2'd1;
                delta   = imm_op ? 3'sd1 : 3'sd0;
                dec.sum = imm_op ? 2'b01 : 2'b00;
            end
            op1 == 3'b010: begin
                dec.mr  = 1'b1;
                dec.sws = 2'b10;
                need    = 2'd1;
            end
            op1 == 3'b011: begin
                dec.mw  = 1'b1;
                dec.sum = 2'b10;
                need    = 2'd2;
                delta   = -3'sd2;
            end
            op1 == 3'b100: begin
                dec.alu = 1'b1;
                dec.sws = 2'b01;
                dec.sum = 2'b11;
                need    = 2'd2;
                delta   = -3'sd1;
            end
            op1 == 3'b101: begin
                dec.pcs = 2'b01;
                dec.sum = 2'b10;
                need    = 2'd2;
                delta   = -3'sd2;
            end
            op1 == 3'b110: begin
                dec.sws = 2'b11;
                dec.sum = 2'b01;
                delta   = 3'sd1;
            end
            default: begin
                dec.pcs = 2'b10;
                dec.sum = 2'b11;
                need    = 2'd1;
                delta   = -3'sd1;
            end
        endcase
    end

    // Checks run on the pre-issue sp, widened so sp+delta cannot wrap.
    assign sum    = $signed({2'b00, sp}) + $signed({{(W-3){delta[2]}}, delta});
    assign under  = sp < (SP_BITS+1)'(need);
    assign over   = sum > $signed(W'(DEPTH));
    assign fetch.instr_ready = (state == RUN) && !reset;
    assign accept = fetch.instr_valid && fetch.instr_ready;

    always_comb begin
        state_n = state;
        sp_n    = sp;
        code_n  = fault_code;
        cv_n    = 1'b0;
        ctrl_n  = '0;
        unique case (state)
            RUN: begin
                if (accept) begin
                    if (under) begin
                        state_n = FAULT;
                        code_n  = 2'b01;
                    end else if (over) begin
                        state_n = FAULT;
                        code_n  = 2'b10;
                    end else begin
                        sp_n   = sum[SP_BITS:0];
                        cv_n   = 1'b1;
                        ctrl_n = dec;
                    end
                end
            end
            FAULT: begin
                if (fault_clear) begin
                    state_n = RUN;
                    code_n  = 2'b00;
                end
            end
            default: state_n = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= RUN;
            sp         <= '0;
            fault_code <= 2'b00;
            ctrl_valid <= 1'b0;
            ctrl_q     <= '0;
        end else begin
            state      <= state_n;
            sp         <= sp_n;
            fault_code <= code_n;
            ctrl_valid <= cv_n;
            ctrl_q     <= ctrl_n;
        end
    end

    assign fault           = (state == FAULT);
    assign ALUOp           = ctrl_q.alu;
    assign PCSrc           = ctrl_q.pcs;
    assign MemRead         = ctrl_q.mr;
    assign MemWrite        = ctrl_q.mw;
    assign StackWriteSrc   = ctrl_q.sws;
    assign ALUSrc          = ctrl_q.as;
    assign StackUpdateMode = ctrl_q.sum;
endmodule

// File: tb/tb_stack_ctrl_seq.sv
// Scoreboard bench for stack_ctrl_seq with a small depth so both stack limits
// are exercised; directed scenarios first, then random traffic.
module tb_stack_ctrl_seq;
    localparam int RB    = 32;
    localparam int SPB   = 2;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic       cv;
        logic [9:0] ctrl;
        logic [2:0] sp;
        logic       flt;
        logic [1:0] fc;
        logic       rdy;
    } obs_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       fault_clear = 1'b0;
    logic       ctrl_valid, ALUOp, MemRead, MemWrite, ALUSrc, fault;
    logic [1:0] PCSrc, StackWriteSrc, StackUpdateMode, fault_code;
    logic [2:0] sp;

    stack_ctrl_seq_if #(.REG_BITS(RB)) fif();

    stack_ctrl_seq #(.REG_BITS(RB), .SP_BITS(SPB)) dut (
        .clk(clk),
        .reset(reset),
        .fetch(fif),
        .fault_clear(fault_clear),
        .ctrl_valid(ctrl_valid),
        .ALUOp(ALUOp),
        .PCSrc(PCSrc),
        .MemRead(MemRead),
        .MemWrite(MemWrite),
        .StackWriteSrc(StackWriteSrc),
        .ALUSrc(ALUSrc),
        .StackUpdateMode(StackUpdateMode),
        .sp(sp),
        .fault(fault),
        .fault_code(fault_code)
    );

    always #5 clk = ~clk;

    obs_t exp_q[$];
    int   vectors = 0;
    int   errors  = 0;
    int   m_sp    = 0;
    bit   m_fault = 0;
    int   m_fc    = 0;
    bit   done    = 0;

    // Decode table: operands needed, sp change, {ALUOp,PCSrc,MR,MW,SWS,ALUSrc,SUM}.
    function automatic void ref_dec(input logic [2:0] o1, input logic [2:0] o2,
                                    output int need, output int d,
                                    output logic [9:0] c);
        bit imm;
        imm = (o2 == 3'b010) || (o2 == 3'b111);
        case (o1)
            3'b000: if (imm) begin need = 1; d = 0;  c = 10'b0_00_0_0_01_0_00; end
                    else     begin need = 2; d = -1; c = 10'b0_00_0_0_01_0_11; end
            3'b001: if (imm) begin need = 0; d = 1;  c = 10'b0_00_0_0_01_1_01; end
                    else     begin need = 1; d = 0;  c = 10'b0_00_0_0_01_1_00; end
            3'b010: begin need = 1; d = 0;  c = 10'b0_00_1_0_10_0_00; end
            3'b011: begin need = 2; d = -2; c = 10'b0_00_0_1_00_0_10; end
            3'b100: begin need = 2; d = -1; c = 10'b1_00_0_0_01_0_11; end
            3'b101: begin need = 2; d = -2; c = 10'b0_01_0_0_00_0_10; end
            3'b110: begin need = 0; d = 1;  c = 10'b0_00_0_0_11_0_01; end
            default: begin need = 1; d = -1; c = 10'b0_10_0_0_00_0_11; end
        endcase
    endfunction

    task automatic step(input bit v, input logic [2:0] o1, input logic [2:0] o2,
                        input bit clr, input bit rs);
        obs_t e;
        int need, d;
        logic [9:0] c;
        @(negedge clk);
        fif.instr_valid = v;
        fif.instruction = {o1, o2, 26'($urandom)};
        fault_clear = clr;
        reset = rs;
        e = '0;
        if (rs) begin
            m_sp = 0; m_fault = 0; m_fc = 0;
            #1;
            vectors++;
            if (ctrl_valid !== 1'b0 || sp !== 3'd0) begin
                errors++;
                $display("FAIL async_reset: ctrl_valid=%b sp=%0d, want 0 and 0", ctrl_valid, sp);
            end
        end else if (!m_fault) begin
            if (v) begin
                ref_dec(o1, o2, need, d, c);
                if (m_sp < need) begin
                    m_fault = 1; m_fc = 1;
                end else if (m_sp + d > DEPTH) begin
                    m_fault = 1; m_fc = 2;
                end else begin
                    m_sp += d;
                    e.cv = 1'b1;
                    e.ctrl = c;
                end
            end
        end else if (clr) begin
            m_fault = 0; m_fc = 0;
        end
        e.sp  = 3'(m_sp);
        e.flt = m_fault;
        e.fc  = 2'(m_fc);
        e.rdy = !rs && !m_fault;
        exp_q.push_back(e);
    endtask

    initial begin : monitor
        obs_t a, e;
        int cyc = 0;
        forever begin
            @(posedge clk);
            #2;
            cyc++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {ctrl_valid, ALUOp, PCSrc, MemRead, MemWrite, StackWriteSrc,
                     ALUSrc, StackUpdateMode, sp, fault, fault_code, fif.instr_ready};
                vectors++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL obs cycle %0d: got cv=%b ctrl=%b sp=%0d flt=%b fc=%b rdy=%b, want cv=%b ctrl=%b sp=%0d flt=%b fc=%b rdy=%b",
                             cyc, a.cv, a.ctrl, a.sp, a.flt, a.fc, a.rdy,
                             e.cv, e.ctrl, e.sp, e.flt, e.fc, e.rdy);
                end
            end
        end
    end

    initial begin : driver
        fif.instr_valid = 1'b0;
        fif.instruction = '0;
        step(0, 3'b000, 3'b000, 0, 1);
        step(0, 3'b000, 3'b000, 0, 1);
        repeat (3) step(1, 3'b110, 3'b000, 0, 0);
        step(1, 3'b000, 3'b000, 0, 0);
        step(1, 3'b100, 3'b000, 0, 0);
        step(1, 3'b111, 3'b000, 0, 0);
        step(1, 3'b000, 3'b000, 0, 0);
        step(1, 3'b110, 3'b000, 0, 0);
        step(0, 3'b000, 3'b000, 1, 0);
        step(0, 3'b000, 3'b000, 1, 0);
        repeat (5) step(1, 3'b110, 3'b000, 0, 0);
        step(0, 3'b000, 3'b000, 1, 0);
        step(1, 3'b001, 3'b000, 0, 0);
        step(1, 3'b001, 3'b010, 0, 0);
        for (int i = 0; i < 6; i++) step(i % 2 == 0, 3'b011, 3'b000, 0, 0);
        step(1, 3'b110, 3'b000, 0, 0);
        step(1, 3'b110, 3'b000, 0, 1);
        step(1, 3'b110, 3'b000, 0, 0);
        for (int i = 0; i < 3000; i++)
            step($urandom_range(3, 0) != 0, 3'($urandom), 3'($urandom),
                 $urandom_range(2, 0) == 0, $urandom_range(99, 0) == 0);
        step(0, 3'b000, 3'b000, 0, 0);
        repeat (3) @(negedge clk);
        vectors++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
